// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// ST_CHECK only exists when IMEM_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int LEN_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_BITS      = BYTES_PER_WORD * 8;

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_ERROR,
    ST_CHECK
`else
    ST_ERROR
`endif
  } state_t;

  // States in which the byte stream is consumed.
  function automatic logic is_intake(input state_t s);
`ifdef IMEM_LOADER_CHECKSUM_EN
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHECK);
`else
    return (s == ST_LEN) || (s == ST_DATA);
`endif
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word packer; word_ready pulses combinationally with the
// final byte of each word, so o_word is valid in that same cycle. Never stalls.
module byte_assembler
  import loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_byte_vld,
  input  logic [7:0]           i_byte,
  output logic [WORD_BITS-1:0] o_word,
  output logic                 o_word_ready
);

  logic [1:0]           r_cnt;
  logic [WORD_BITS-9:0] r_bytes;
  logic                 w_last;

  assign w_last       = (r_cnt == 2'(BYTES_PER_WORD - 1));
  assign o_word_ready = i_byte_vld && w_last && !i_clear;
  // The last byte bypasses the shift register so the word is usable immediately.
  assign o_word       = {i_byte, r_bytes};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= 2'd0;
      r_bytes <= '0;
    end else if (i_clear) begin
      r_cnt   <= 2'd0;
    end else if (i_byte_vld) begin
      r_cnt   <= r_cnt + 2'd1;
      r_bytes <= {i_byte, r_bytes[WORD_BITS-9:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: LE length header then N LE words, one mem_write per word; in_ready
// drops during each write and once finished. Optional checksum via IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import loader_pkg::*;
#(
  parameter int                      ADDRESS_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0] BOOT_ADDRESS = 32'h1000,
  parameter logic [ADDRESS_SIZE-1:0] MEM_SIZE     = 32'h1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    mem_write,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic [ADDRESS_SIZE-1:0] mem_data,
  output logic                    core_hold,
  output logic                    done,
  output logic                    error
);

  // Comparing N against capacity/4 avoids the overflow of computing N*4.
  localparam logic [ADDRESS_SIZE-1:0] MAX_WORDS = MEM_SIZE >> 2;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t ST_END = ST_CHECK;
`else
  localparam state_t ST_END = ST_DONE;
`endif

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDRESS_SIZE-1:0] r_word_cnt;
  logic [ADDRESS_SIZE-1:0] r_k;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic [ADDRESS_SIZE-1:0] r_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]              r_csum;
`endif

  logic                    w_accept;
  logic                    w_asm_vld;
  logic                    w_asm_clear;
  logic                    w_word_ready;
  logic [WORD_BITS-1:0]    w_asm_word;
  logic [ADDRESS_SIZE-1:0] w_word;
  logic                    w_last_word;

  assign w_accept    = in_valid && in_ready;
  assign w_asm_vld   = w_accept && ((r_state == ST_LEN) || (r_state == ST_DATA));
  assign w_asm_clear = !((r_state == ST_LEN) || (r_state == ST_DATA));
  assign w_word      = ADDRESS_SIZE'(w_asm_word);
  assign w_last_word = ((r_k + 1'b1) == r_word_cnt);

  assign mem_address = r_addr;
  assign mem_data    = r_data;

  byte_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_asm_clear),
    .i_byte_vld   (w_asm_vld),
    .i_byte       (in_data),
    .o_word       (w_asm_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_LEN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = is_intake(r_state);
    mem_write    = 1'b0;
    core_hold    = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (r_state)
      ST_LEN: begin
        if (w_word_ready) begin
          if (w_word == '0) begin
            w_next_state = ST_END;
          end else if (w_word > MAX_WORDS) begin
            w_next_state = ST_ERROR;
          end else begin
            w_next_state = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_word_ready) begin
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_write    = 1'b1;
        w_next_state = w_last_word ? ST_END : ST_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (w_accept) begin
          w_next_state = (in_data == r_csum) ? ST_DONE : ST_ERROR;
        end
      end
`endif
      ST_DONE: begin
        core_hold = 1'b0;
        done      = 1'b1;
      end
      ST_ERROR: begin
        error = 1'b1;
      end
      default: begin
        w_next_state = r_state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_cnt <= '0;
      r_k        <= '0;
      r_addr     <= BOOT_ADDRESS;
      r_data     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum     <= 8'h00;
`endif
    end else begin
      case (r_state)
        ST_LEN: begin
          if (w_word_ready) begin
            r_word_cnt <= w_word;
            r_k        <= '0;
            r_addr     <= BOOT_ADDRESS;
          end
        end
        ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (w_asm_vld) begin
            r_csum <= r_csum ^ in_data;
          end
`endif
          if (w_word_ready) begin
            r_data <= w_word;
          end
        end
        ST_WRITE: begin
          r_k    <= r_k + 1'b1;
          r_addr <= r_addr + ADDRESS_SIZE'(BYTES_PER_WORD);
        end
        default: begin
          r_k <= r_k;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a queue-based model of the image stream.
// Honors IMEM_LOADER_CHECKSUM_EN by appending the XOR checksum byte.
module tb_imem_loader;

  localparam logic [31:0] BOOT = 32'h1000;
  localparam int          MAXW = 32'h1000 / 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        core_hold;
  logic        done;
  logic        error;

  int          n_chk = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] pl[$];

  imem_loader #(
    .ADDRESS_SIZE (32),
    .BOOT_ADDRESS (32'h1000),
    .MEM_SIZE     (32'h1000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .core_hold   (core_hold),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Record every write strobe; while loading, in_ready must be low exactly on write cycles.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_write) begin
        wr_addr_q.push_back(mem_address);
        wr_data_q.push_back(mem_data);
      end
      if (reset && !done && !error) check("rdy_vs_wr", in_ready, !mem_write);
    end
  end

  task automatic check_reset_vals();
    check("rst_in_ready",  in_ready,    1);
    check("rst_mem_write", mem_write,   0);
    check("rst_mem_addr",  mem_address, BOOT);
    check("rst_mem_data",  mem_data,    0);
    check("rst_core_hold", core_hold,   1);
    check("rst_done",      done,        0);
    check("rst_error",     error,       0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
  endtask

  // gap: 0 back-to-back, 1 one idle cycle per byte, 2 random idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    int w;
    g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 3)) : 0;
    repeat (g) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("rdy_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic wait_end();
    int w;
    w = 0;
    while (!(done || error) && w < 20) begin
      @(negedge clk);
      w++;
    end
  endtask

  // Model: a header N <= capacity/4 yields N writes at BOOT+4k; anything larger aborts.
  task automatic run_load(input logic [31:0] n, input int gap, input bit bad_csum);
    bit         ok;
    bit         exp_done;
    int         nw;
    logic [7:0] x;
    logic [31:0] w;
    ok = (n <= MAXW);
    nw = ok ? int'(n) : 0;
    exp_done = ok;
    wr_addr_q.delete();
    wr_data_q.delete();
    while (pl.size() < nw) pl.push_back($urandom);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gap);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (n == 0) check("n0_done_next", done, 1);
`endif
    x = 8'h00;
    for (int k = 0; k < nw; k++) begin
      w = pl[k];
      for (int i = 0; i < 4; i++) begin
        send_byte(w[8*i +: 8], gap);
        x = x ^ w[8*i +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (ok) send_byte(bad_csum ? (x ^ 8'h01) : x, gap);
    if (bad_csum) exp_done = 1'b0;
`endif
    wait_end();
    check("end_done",      done,      exp_done);
    check("end_error",     error,     !exp_done);
    check("end_core_hold", core_hold, !exp_done);
    check("end_in_ready",  in_ready,  0);
    check("wr_count",      wr_addr_q.size(), nw);
    for (int k = 0; k < nw && k < wr_addr_q.size(); k++) begin
      check("wr_addr", wr_addr_q[k], BOOT + 32'(4 * k));
      check("wr_data", wr_data_q[k], pl[k]);
    end
    pl.delete();
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    check_reset_vals();
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;

    pl.push_back(32'h12345678);
    run_load(32'd1, 0, 1'b0);

    apply_reset();
    run_load(32'd0, 0, 1'b0);

    apply_reset();
    run_load(32'd1025, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (5) @(negedge clk);
    check("err_hold_rdy", in_ready, 0);
    check("err_sticky",   error,    1);
    in_valid = 1'b0;

    apply_reset();
    run_load(32'd3, 1, 1'b0);

    // Reset lands in the cycle of the second of three writes.
    apply_reset();
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int k = 0; k < 3; k++) pl.push_back($urandom);
    for (int i = 0; i < 4; i++) send_byte(8'(i == 0 ? 3 : 0), 0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) send_byte(8'(pl[k] >> (8 * i)), 0);
    end
    check("pre_rst_write", mem_write, 1);
    reset = 1'b0;
    #1;
    check_reset_vals();
    check("mid_rst_wr_count", wr_addr_q.size(), 1);
    pl.delete();
    @(negedge clk);
    reset = 1'b1;
    run_load(32'd1, 2, 1'b0);

    for (int t = 0; t < 6; t++) begin
      apply_reset();
      run_load(32'($urandom_range(1, 8)), 2, 1'b0);
    end

    apply_reset();
    run_load(32'd1024, 0, 1'b0);
    apply_reset();
    run_load(32'h4000_0000, 0, 1'b0);
    apply_reset();
    run_load(32'hFFFF_FFFF, 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    apply_reset();
    pl.push_back(32'h12345678);
    run_load(32'd1, 0, 1'b1);
    apply_reset();
    pl.push_back(32'h12345678);
    run_load(32'd1, 0, 1'b0);
`endif

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 32, width of address and data words.
REQ-002 SHALL have parameter BOOT_ADDRESS, default 32'h1000, first instruction-memory address written.
REQ-003 SHALL have parameter MEM_SIZE, default 32'h1000, instruction-memory capacity in bytes.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  byte-stream data valid.
REQ-007 SHALL have port in_data  input  8  byte-stream payload.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte when in_valid and in_ready are both high.
REQ-009 SHALL have port mem_write  output  1  one-cycle instruction-memory write strobe.
REQ-010 SHALL have port mem_address  output  ADDRESS_SIZE  word write address.
REQ-011 SHALL have port mem_data  output  ADDRESS_SIZE  word write data.
REQ-012 SHALL have port core_hold  output  1  high holds the datapath out of execution until load completes.
REQ-013 SHALL have port done  output  1  load completed successfully (sticky).
REQ-014 SHALL have port error  output  1  load aborted (sticky).

Function
REQ-015 SHALL implement states LEN, DATA, WRITE, DONE, ERROR; exit from reset into LEN.
REQ-016 In LEN, SHALL accept 4 bytes, little-endian, forming word count N.
REQ-017 After the 4th LEN byte: N==0 -> DONE; N*4 > MEM_SIZE -> ERROR; otherwise -> DATA.
REQ-018 In DATA, SHALL accept 4 bytes little-endian into one word, then go to WRITE.
REQ-019 In WRITE, SHALL assert mem_write for exactly one cycle, with mem_address = BOOT_ADDRESS + 4*k (k = 0..N-1) and mem_data = assembled word, both stable that cycle.
REQ-020 in_ready SHALL be high in LEN and DATA only; low in WRITE, DONE, ERROR.
REQ-021 After WRITE: k+1 == N -> DONE; otherwise -> DATA with k incremented.
REQ-022 in_valid low SHALL stall without losing partial-word bytes; gaps of any length are legal.
REQ-023 Word count and address arithmetic SHALL be ADDRESS_SIZE bits; the N*4 comparison SHALL not wrap (N >= 2^(ADDRESS_SIZE-2) -> ERROR).
REQ-024 core_hold SHALL be high in every state except DONE; in ERROR it remains high.
REQ-025 DONE and ERROR SHALL be terminal until reset; bytes offered there are not consumed.

Reset
REQ-026 On reset low, immediately: state LEN, byte and word counters 0, in_ready 1, mem_write 0, mem_address BOOT_ADDRESS, mem_data 0, core_hold 1, done 0, error 0.
REQ-027 Reset mid-WRITE SHALL suppress the strobe in the same cycle; a partially loaded image is discarded and loading restarts at the header.

Configuration
REQ-028 With IMEM_LOADER_CHECKSUM_EN defined, after the last payload word a CHECK state SHALL accept one byte; equal to XOR of all payload bytes -> DONE, otherwise ERROR; for N==0 the expected value is 8'h00.
REQ-029 Without IMEM_LOADER_CHECKSUM_EN, no CHECK state exists and the stream ends after the last payload byte.

Structure
REQ-030 A shared package loader_pkg SHALL hold the state enumeration, LEN_BYTES = 4 and BYTES_PER_WORD = 4.
REQ-031 A sub-module byte_assembler (byte shift-in, 2-bit byte counter, word_ready pulse, clear input) SHALL be used for both LEN and DATA word formation.

Verification
REQ-032 Header 01 00 00 00, payload 78 56 34 12 -> single mem_write, address 32'h1000, data 32'h12345678; done=1, core_hold=0.
REQ-033 Header 00 00 00 00 -> no mem_write; done=1 on cycle after 4th byte.
REQ-034 Header 01 04 00 00 (N=1025, MEM_SIZE 4096) -> error=1, no mem_write, in_ready=0 thereafter.
REQ-035 N=3 with in_valid toggled every other cycle -> writes at 32'h1000, 32'h1004, 32'h1008 with correct data; in_ready low exactly on each WRITE cycle.
REQ-036 Reset asserted after 2 of 3 words -> outputs at reset values; fresh N=1 load then succeeds at 32'h1000.
REQ-037 With IMEM_LOADER_CHECKSUM_EN, payload 78 56 34 12 plus checksum 08 -> done; plus checksum 09 -> error, core_hold stays 1.
